// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/result bus for the seq_mult iterative multiplier.
//
// Handshake rules, identical on both sides of the block: a transfer happens
// on a rising clock edge where valid and ready are both high. A source keeps
// valid and its payload stable until that edge. A sink may raise or drop
// ready freely. Here in_ready is high only while the multiplier is idle, and
// out_valid is high only while a finished product waits to be taken, so the
// input and output transfers can never happen on the same edge.
interface seq_mult_if #(
    parameter int WIDTH = 4
);
    // Operand side: the source drives these, the multiplier accepts them.
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic               signed_mode;

    // Result side: the multiplier offers these, the consumer takes them.
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] outv;

    // Operand source and result consumer (the testbench or the surrounding logic).
    modport master (
        output in_valid,
        output in1,
        output in2,
        output signed_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  outv
    );

    // The multiplier itself.
    modport slave (
        input  in_valid,
        input  in1,
        input  in2,
        input  signed_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output outv
    );
endinterface

// File: rtl/seq_mult.sv
// seq_mult: parametrised iterative shift-add multiplier, one operation in flight.
//
// Operands are accepted in IDLE. The block multiplies their magnitudes over
// WIDTH CALC cycles, one multiplier bit per cycle. It then applies the sign
// and holds the product in DONE until the consumer takes it.
//
// Optional macro SEQ_MULT_EARLY_TERM_EN: when it is defined, CALC ends as
// soon as the remaining multiplier bits are all zero. Latency then depends on
// the operand. When it is undefined, latency is a fixed WIDTH cycles for every
// operand pair.
//
// WIDTH must lie in 2..16. The product width is 2*WIDTH. The most negative
// signed operand has magnitude 2^(WIDTH-1), and that still fits in WIDTH
// unsigned bits, so the magnitude path never overflows.
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_mult_if.slave  bus,
    output logic [1:0] state_dbg
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic [PW-1:0]    outv_r;
    logic             in_ready_r;
    logic             out_valid_r;

    // Operand magnitudes and sign of the result, derived from the live inputs.
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             neg_in;

    // Next values for one shift-add iteration and the product it would finish with.
    logic [PW-1:0]    acc_nxt;
    logic [WIDTH-1:0] mplier_nxt;
    logic [PW-1:0]    prod;
    logic             last;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.outv      = outv_r;
    assign state_dbg     = state;

    // Absolute values of the operands. In unsigned mode they pass through unchanged.
    always_comb begin
        mag1   = bus.in1;
        mag2   = bus.in2;
        neg_in = 1'b0;
        if (bus.signed_mode) begin
            if (bus.in1[WIDTH-1]) begin
                mag1 = -bus.in1;
            end
            if (bus.in2[WIDTH-1]) begin
                mag2 = -bus.in2;
            end
            neg_in = bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
        end
    end

    // One iteration: conditional add, multiplier shift, and detection of the final step.
    always_comb begin
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        mplier_nxt = mplier >> 1;
        // Negating zero gives zero, so a zero product never comes out with its sign set.
        prod       = neg ? (~acc_nxt + 1'b1) : acc_nxt;
`ifdef SEQ_MULT_EARLY_TERM_EN
        // Nothing is left to add once the shifted multiplier reaches zero.
        last       = (cnt == CNT_LAST) || (mplier_nxt == '0);
`else
        last       = (cnt == CNT_LAST);
`endif
    end

    // Control FSM and datapath registers. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            outv_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand      <= {{WIDTH{1'b0}}, mag1};
                        mplier     <= mag2;
                        neg        <= neg_in;
                        acc        <= '0;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        outv_r      <= prod;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // outv_r is left untouched so the last product stays visible while idle.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
